aes256_key_sched_ctrl: RTL and testbench

Sequencer and round-key store for the shared AES-256 `key_expansion` engine. It accepts a 256-bit cipher key and drives the engine's `current_state`, `round`, `cnt`, `inv_en` and `key_in` inputs through all 15 round keys. It captures each 128-bit round key into an internal 15-entry store and streams it out as it is generated. After expansion, the cipher core (encrypt order) or the inverse core (reverse order) reads the keys by index, so the engine is used only once per rekey.

---
 rtl/aes256_key_sched_ctrl_if.sv | 36 +++
 rtl/aes256_key_sched_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes256_key_sched_ctrl_if.sv
// Bus between the AES-256 key-schedule sequencer and its neighbours: key load,
// key_expansion engine drive, round-key stream and round-key read port.
interface aes256_key_sched_ctrl_if #(
    parameter int KEY_WIDTH = 256
);
    logic                 key_valid;
    logic [KEY_WIDTH-1:0] key;
    logic                 key_ready;
    logic                 busy;
    logic [3:0]           ke_state;
    logic [3:0]           ke_round;
    logic [4:0]           ke_cnt;
    logic                 ke_inv_en;
    logic [KEY_WIDTH-1:0] ke_key;
    logic [127:0]         ke_round_key;
    logic                 rk_valid;
    logic [3:0]           rk_idx;
    logic [127:0]         rk_data;
    logic                 keys_ready;
    logic                 rd_en;
    logic [3:0]           rd_idx;
    logic                 rd_valid;
    logic [127:0]         rd_key;

    modport slave (
        input  key_valid, key, ke_round_key, rd_en, rd_idx,
        output key_ready, busy, ke_state, ke_round, ke_cnt, ke_inv_en, ke_key,
               rk_valid, rk_idx, rk_data, keys_ready, rd_valid, rd_key
    );

    modport master (
        output key_valid, key, ke_round_key, rd_en, rd_idx,
        input  key_ready, busy, ke_state, ke_round, ke_cnt, ke_inv_en, ke_key,
               rk_valid, rk_idx, rk_data, keys_ready, rd_valid, rd_key
    );
endinterface

// File: rtl/aes256_key_sched_ctrl.sv
// Sequences the shared AES-256 key_expansion engine through all round keys once
// per rekey, stores them and serves indexed reads for the cipher cores.
module aes256_key_sched_ctrl #(
    parameter int KEY_WIDTH = 256,
    parameter int NR        = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    aes256_key_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_e;

    localparam logic [3:0] LAST_ROUND  = 4'(NR);
    localparam logic [4:0] CNT_CAPTURE = 5'd6;
    localparam logic [3:0] KE_IDLE     = 4'd0;
    localparam logic [3:0] KE_ADDRK    = 4'd1;

    state_e               state_q, state_d;
    logic [3:0]           ke_state_q, ke_state_d;
    logic [3:0]           round_q, round_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] ke_key_q, ke_key_d;
    logic                 keys_ready_q, keys_ready_d;
    logic                 rk_valid_q, rk_valid_d;
    logic [3:0]           rk_idx_q, rk_idx_d;
    logic [127:0]         rk_data_q, rk_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [127:0]         rd_key_q, rd_key_d;

    logic [127:0]         store_mem [NR+1];
    logic                 key_ready;
    logic                 accept;
    logic                 capture;
    logic                 rd_hit;

    assign key_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept    = bus.key_valid && key_ready;
    // cnt=6 is the engine's inert step, so its round_key output is stable here
    assign capture   = (state_q == S_EXPAND) && (cnt_q == CNT_CAPTURE);
    assign rd_hit    = bus.rd_en && keys_ready_q && (bus.rd_idx <= LAST_ROUND);

    always_comb begin
        state_d      = state_q;
        ke_state_d   = ke_state_q;
        round_d      = round_q;
        cnt_d        = cnt_q;
        ke_key_d     = ke_key_q;
        keys_ready_d = keys_ready_q;
        rk_valid_d   = 1'b0;
        rk_idx_d     = rk_idx_q;
        rk_data_d    = rk_data_q;
        rd_valid_d   = 1'b0;
        rd_key_d     = rd_key_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d      = S_LOAD;
                    ke_key_d     = bus.key;
                    keys_ready_d = 1'b0;
                end
            end
            S_LOAD: begin
                state_d    = S_EXPAND;
                ke_state_d = KE_ADDRK;
                round_d    = 4'd0;
                cnt_d      = CNT_CAPTURE;
            end
            S_EXPAND: begin
                if (capture) begin
                    rk_valid_d = 1'b1;
                    rk_idx_d   = round_q;
                    rk_data_d  = bus.ke_round_key;
                    if (round_q == LAST_ROUND) begin
                        state_d      = S_DONE;
                        ke_state_d   = KE_IDLE;
                        keys_ready_d = 1'b1;
                        round_d      = 4'd0;
                        cnt_d        = 5'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                        // round 1 is a direct key half like round 0; later rounds run the full 7-step sequence
                        cnt_d   = (round_q == 4'd0) ? CNT_CAPTURE : 5'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_hit) begin
            rd_valid_d = 1'b1;
            rd_key_d   = store_mem[bus.rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ke_state_q   <= KE_IDLE;
            round_q      <= 4'd0;
            cnt_q        <= 5'd0;
            ke_key_q     <= '0;
            keys_ready_q <= 1'b0;
            rk_valid_q   <= 1'b0;
            rk_idx_q     <= 4'd0;
            rk_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_key_q     <= '0;
        end else begin
            state_q      <= state_d;
            ke_state_q   <= ke_state_d;
            round_q      <= round_d;
            cnt_q        <= cnt_d;
            ke_key_q     <= ke_key_d;
            keys_ready_q <= keys_ready_d;
            rk_valid_q   <= rk_valid_d;
            rk_idx_q     <= rk_idx_d;
            rk_data_q    <= rk_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_key_q     <= rd_key_d;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            store_mem[round_q] <= bus.ke_round_key;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.busy       = (state_q == S_LOAD) || (state_q == S_EXPAND);
    assign bus.ke_state   = ke_state_q;
    assign bus.ke_round   = round_q;
    assign bus.ke_cnt     = cnt_q;
    assign bus.ke_inv_en  = 1'b0;
    assign bus.ke_key     = ke_key_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_idx     = rk_idx_q;
    assign bus.rk_data    = rk_data_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_key     = rd_key_q;
endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: an AES-256 key_expansion engine stand-in plus
// a FIPS-197 key-schedule reference model, with directed and random keys.
module tb_aes256_key_sched_ctrl;
    localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes256_key_sched_ctrl_if bus ();
    aes256_key_sched_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_next = 0;
    int pulses = 0;
    bit armed = 1'b0;
    logic [14:0][127:0] exp_sched;
    logic [14:0][127:0] c3_sched;
    logic [14:0][127:0] eng_sched;
    logic [127:0] got [15];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [14:0][127:0] expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [14:0][127:0] rks;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rks;
    endfunction

    function automatic int cap_edge(input int r);
        return (r < 2) ? r + 2 : 7*r - 4;
    endfunction

    // Engine stand-in: loads its key while held in state 0 during LOAD, and shows a
    // round key only on the inert cnt=6 step; garbage elsewhere exposes mistimed captures.
    always @(posedge clk) begin
        if (bus.busy && bus.ke_state == 4'd0) eng_sched <= expand(bus.ke_key);
    end
    assign bus.ke_round_key = (bus.ke_state == 4'd1 && bus.ke_cnt == 5'd6 && bus.ke_round <= 4'd14)
                              ? eng_sched[bus.ke_round] : {4{32'hdeadbeef}};

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (bus.rk_valid) begin
            if (!armed) begin
                check("rk_unexpected", bus.rk_valid, 1'b0);
            end else begin
                check("rk_idx", bus.rk_idx, exp_next);
                check("rk_time", cyc - acc_cyc, cap_edge(exp_next));
                if (bus.rk_idx <= 4'd14) begin
                    check("rk_data", bus.rk_data, exp_sched[bus.rk_idx]);
                    got[bus.rk_idx] = bus.rk_data;
                end
                exp_next++;
                pulses++;
            end
        end
    endtask

    task automatic run_to(input int k);
        while (cyc - acc_cyc < k) tick();
    endtask

    task automatic start_key(input logic [255:0] k);
        bus.key       = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        acc_cyc   = cyc;
        exp_sched = expand(k);
        exp_next  = 0;
        pulses    = 0;
        armed     = 1'b1;
        check("accept_busy", bus.busy, 1'b1);
        check("accept_keys_ready", bus.keys_ready, 1'b0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.keys_ready && n < 200) begin
            tick();
            n++;
        end
        check("done_timeout", bus.keys_ready, 1'b1);
        check("ready_latency", cyc - acc_cyc, 94);
        check("pulse_count", pulses, 15);
        check("busy_done", bus.busy, 1'b0);
        check("key_ready_done", bus.key_ready, 1'b1);
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = 4'd0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_key_ready", bus.key_ready, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_keys_ready", bus.keys_ready, 1'b0);
        check("rst_rk_valid", bus.rk_valid, 1'b0);
        check("rst_rk_idx", bus.rk_idx, 0);
        check("rst_rk_data", bus.rk_data, 0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_key", bus.rd_key, 0);
        check("rst_ke_state", bus.ke_state, 0);
        check("rst_ke_round", bus.ke_round, 0);
        check("rst_ke_cnt", bus.ke_cnt, 0);
        check("rst_ke_inv_en", bus.ke_inv_en, 1'b0);
        check("rst_ke_key", bus.ke_key, 0);

        // FIPS-197 C.3 key with a read and an ignored rekey during expansion
        start_key(K_C3);
        check("load_ke_state", bus.ke_state, 0);
        check("load_ke_key", bus.ke_key, K_C3);
        tick();
        check("expand_ke_state", bus.ke_state, 1);
        check("expand_r0_cnt", bus.ke_cnt, 6);
        run_to(20);
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'd3;
        tick();
        bus.rd_en = 1'b0;
        check("rd_during_expand", bus.rd_valid, 1'b0);
        run_to(39);
        bus.key       = K_A3;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        check("busy_ignored", bus.busy, 1'b1);
        check("ke_key_kept", bus.ke_key, K_C3);
        wait_done();
        check("c3_rk0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
        check("c3_rk1", got[1], 128'h101112131415161718191a1b1c1d1e1f);
        check("c3_rk2", got[2], 128'ha573c29fa176c498a97fce93a572c09c);
        check("c3_rk14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        c3_sched = exp_sched;

        for (int i = 14; i >= 0; i--) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'(i);
            tick();
            check("rd_valid", bus.rd_valid, 1'b1);
            check("rd_key", bus.rd_key, got[i]);
        end
        bus.rd_idx = 4'd15;
        tick();
        bus.rd_en = 1'b0;
        check("rd_idx15_valid", bus.rd_valid, 1'b0);
        check("rd_idx15_hold", bus.rd_key, c3_sched[0]);

        // rekey in DONE with a read on the accept edge served from the old store
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'd7;
        start_key(K_A3);
        bus.rd_en = 1'b0;
        check("rd_at_accept_valid", bus.rd_valid, 1'b1);
        check("rd_at_accept_key", bus.rd_key, c3_sched[7]);
        wait_done();
        check("a3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // back-to-back random keys accepted in the first DONE cycle
        for (int n = 0; n < 2; n++) begin
            start_key(rand_key());
            wait_done();
        end
        bus.rd_en  = 1'b1;
        bus.rd_idx = 4'd9;
        tick();
        bus.rd_en = 1'b0;
        check("rand_rd_key", bus.rd_key, exp_sched[9]);

        // reset mid-expansion
        start_key(rand_key());
        run_to(49);
        rst   = 1'b1;
        armed = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_keys_ready", bus.keys_ready, 1'b0);
        check("midrst_key_ready", bus.key_ready, 1'b1);
        check("midrst_ke_state", bus.ke_state, 0);
        check("midrst_ke_round", bus.ke_round, 0);
        check("midrst_ke_cnt", bus.ke_cnt, 0);
        check("midrst_rk_valid", bus.rk_valid, 1'b0);
        check("midrst_ke_key", bus.ke_key, 0);
        repeat (6) tick();
        check("midrst_idle_keys_ready", bus.keys_ready, 1'b0);
        start_key(rand_key());
        wait_done();
        for (int i = 0; i < 3; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_idx = 4'($urandom_range(0, 14));
            tick();
            check("post_rst_rd_key", bus.rd_key, exp_sched[bus.rd_idx]);
        end
        bus.rd_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
